cla_chunk_sequencer: RTL and testbench

CLA_CHUNK_SEQUENCER -- requirements
Module: cla_chunk_sequencer

---
 rtl/cla_chunk_sequencer.sv | 127 ++++++++++++
 tb/tb_cla_chunk_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_chunk_sequencer.sv
// Nibble-serial adder sequencer: walks a wide operand pair through an external
// 4-bit CLA one nibble at a time, rippling the carry through a local register.
module cla_chunk_sequencer #(
  parameter int NIB    = 4,
  parameter int SETTLE = 1
) (
  input  logic              Clk,
  input  logic              Rs,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NIB-1:0]  in_a,
  input  logic [4*NIB-1:0]  in_b,
  input  logic              in_cin,
  output logic [3:0]        cla_a,
  output logic [3:0]        cla_b,
  output logic              cla_cin,
  input  logic [3:0]        cla_sum,
  input  logic              cla_cout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NIB-1:0]  out_sum,
  output logic              out_cout,
  output logic              busy
);

  localparam int W  = 4 * NIB;
  localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NIB - 1);
  localparam logic [2:0]    SETTLE_CNT = 3'(SETTLE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e         state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [W-1:0]   sum_q;
  logic           carry_q;
  logic [IW-1:0]  idx_q;
  logic [IW-1:0]  idx_d;
  logic [2:0]     cnt_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic           busy_q;
  logic [3:0]     cla_a_q;
  logic [3:0]     cla_b_q;
  logic           cla_cin_q;

  assign idx_d = idx_q + IW'(1);

  // The CLA-facing nibble is registered, so it is preloaded with the next
  // nibble on the same edge that samples the current one.
  always_ff @(posedge Clk or negedge Rs) begin
    if (!Rs) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cla_a_q     <= '0;
      cla_b_q     <= '0;
      cla_cin_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            carry_q    <= in_cin;
            idx_q      <= '0;
            cnt_q      <= '0;
            cla_a_q    <= in_a[3:0];
            cla_b_q    <= in_b[3:0];
            cla_cin_q  <= in_cin;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (cnt_q < SETTLE_CNT) begin
            cnt_q <= cnt_q + 3'd1;
          end else begin
            cnt_q                     <= '0;
            sum_q[{idx_q, 2'b00} +: 4] <= cla_sum;
            carry_q                   <= cla_cout;
            if (idx_q == LAST_IDX) begin
              out_valid_q <= 1'b1;
              cla_a_q     <= '0;
              cla_b_q     <= '0;
              cla_cin_q   <= 1'b0;
              state_q     <= DONE;
            end else begin
              idx_q     <= idx_d;
              cla_a_q   <= a_q[{idx_d, 2'b00} +: 4];
              cla_b_q   <= b_q[{idx_d, 2'b00} +: 4];
              cla_cin_q <= cla_cout;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign cla_a     = cla_a_q;
  assign cla_b     = cla_b_q;
  assign cla_cin   = cla_cin_q;
  assign out_sum   = sum_q;
  assign out_cout  = carry_q;

endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// Self-checking bench: three sequencers (SETTLE 0, 1, 3) each driving a
// behavioural zero-delay CLA, checked by vector table, directed cases and a scoreboard.
module tb_cla_chunk_sequencer;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic          Clk;
  logic          Rs;
  logic [2:0]    inValid, inReady, inCin, claCin, claCout, outValid, outReady, outCout, busy;
  logic [W-1:0]  inA [3];
  logic [W-1:0]  inB [3];
  logic [W-1:0]  outSum [3];
  logic [3:0]    claA [3];
  logic [3:0]    claB [3];
  logic [3:0]    claSum [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int curK = 1;
  bit monEn = 0;
  bit prevValid = 0;

  typedef struct {
    logic [16:0] exp;
    int          due;
  } sb_t;
  sb_t sbQ[$];
  sb_t sbE;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  cla_chunk_sequencer #(.NIB(NIB), .SETTLE(0)) dut0 (
    .Clk(Clk), .Rs(Rs), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_a(inA[0]), .in_b(inB[0]), .in_cin(inCin[0]),
    .cla_a(claA[0]), .cla_b(claB[0]), .cla_cin(claCin[0]),
    .cla_sum(claSum[0]), .cla_cout(claCout[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_sum(outSum[0]), .out_cout(outCout[0]), .busy(busy[0]));

  cla_chunk_sequencer #(.NIB(NIB), .SETTLE(1)) dut1 (
    .Clk(Clk), .Rs(Rs), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_a(inA[1]), .in_b(inB[1]), .in_cin(inCin[1]),
    .cla_a(claA[1]), .cla_b(claB[1]), .cla_cin(claCin[1]),
    .cla_sum(claSum[1]), .cla_cout(claCout[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_sum(outSum[1]), .out_cout(outCout[1]), .busy(busy[1]));

  cla_chunk_sequencer #(.NIB(NIB), .SETTLE(3)) dut3 (
    .Clk(Clk), .Rs(Rs), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .in_a(inA[2]), .in_b(inB[2]), .in_cin(inCin[2]),
    .cla_a(claA[2]), .cla_b(claB[2]), .cla_cin(claCin[2]),
    .cla_sum(claSum[2]), .cla_cout(claCout[2]),
    .out_valid(outValid[2]), .out_ready(outReady[2]),
    .out_sum(outSum[2]), .out_cout(outCout[2]), .busy(busy[2]));

  for (genvar g = 0; g < 3; g++) begin : g_cla
    assign {claCout[g], claSum[g]} = 5'(claA[g]) + 5'(claB[g]) + 5'(claCin[g]);
  end

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic int latOf(input int k);
    return NIB * (((k == 0) ? 0 : (k == 1) ? 1 : 3) + 1);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: push the model result when an accept is about to happen,
  // check latency when out_valid rises, pop and compare at the result handshake.
  always @(negedge Clk) begin
    if (monEn && Rs) begin
      if (inValid[curK] && inReady[curK]) begin
        sbE.exp = {1'b0, inA[curK]} + {1'b0, inB[curK]} + 17'(inCin[curK]);
        sbE.due = cyc + 1 + latOf(curK);
        sbQ.push_back(sbE);
      end
      if (outValid[curK] && !prevValid) begin
        if (sbQ.size() == 0) checkOutput("sb_pending_at_valid", sbQ.size(), 1);
        else checkOutput("sb_latency", cyc, sbQ[0].due);
      end
      prevValid = outValid[curK];
      if (outValid[curK] && outReady[curK]) begin
        if (sbQ.size() == 0) begin
          checkOutput("sb_pending_at_pop", sbQ.size(), 1);
        end else begin
          sbE = sbQ.pop_front();
          checkOutput("sb_sum", outSum[curK], sbE.exp[15:0]);
          checkOutput("sb_cout", outCout[curK], sbE.exp[16]);
        end
      end
    end
  end

  // All tasks assume they are entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input int k, input logic [15:0] a, input logic [15:0] b, input logic cin);
    int t = 0;
    while (!inReady[k] && t < 100) begin
      @(posedge Clk); #1;
      t++;
    end
    checkOutput("in_ready_before_accept", inReady[k], 1);
    inA[k] = a;
    inB[k] = b;
    inCin[k] = cin;
    inValid[k] = 1'b1;
    @(posedge Clk); #1;
    inValid[k] = 1'b0;
  endtask

  task automatic waitValid(input int k, output int n);
    n = 0;
    while (!outValid[k] && n < 200) begin
      @(posedge Clk); #1;
      n++;
    end
  endtask

  task automatic checkResetState(input int k);
    checkOutput("rst_in_ready", inReady[k], 1);
    checkOutput("rst_out_valid", outValid[k], 0);
    checkOutput("rst_out_sum", outSum[k], 0);
    checkOutput("rst_out_cout", outCout[k], 0);
    checkOutput("rst_busy", busy[k], 0);
    checkOutput("rst_cla_a", claA[k], 0);
    checkOutput("rst_cla_b", claB[k], 0);
    checkOutput("rst_cla_cin", claCin[k], 0);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs[10];
    logic expCin[4];
    int n;
    bit seen;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[3] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0};
    vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[9] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    expCin[0] = 1'b0;
    expCin[1] = 1'b1;
    expCin[2] = 1'b1;
    expCin[3] = 1'b1;

    Rs = 1'b0;
    inValid = '0;
    inCin = '0;
    outReady = '1;
    for (int k = 0; k < 3; k++) begin
      inA[k] = '0;
      inB[k] = '0;
    end

    repeat (2) @(posedge Clk);
    #1;
    checkResetState(1);
    @(negedge Clk);
    Rs = 1'b1;
    @(posedge Clk); #1;
    monEn = 1'b1;
    curK = 1;

    // Vector table on the default-parameter instance
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, vecs[i].a, vecs[i].b, vecs[i].cin);
      waitValid(1, n);
      checkOutput("tbl_latency", n, 8);
      checkOutput("tbl_sum", outSum[1], vecs[i].sum);
      checkOutput("tbl_cout", outCout[1], vecs[i].cout);
      @(posedge Clk); #1;
      checkOutput("tbl_back_to_idle", inReady[1], 1);
    end

    // Carry ripple visible on cla_cin, with in_valid noise during RUN
    applyStimulus(1, 16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ripple_cla_cin", claCin[1], expCin[i]);
      checkOutput("ripple_cla_a", claA[1], 4'hF);
      checkOutput("ripple_in_ready_low", inReady[1], 0);
      inValid[1] = 1'b1;
      inA[1] = 16'h1234;
      repeat (2) @(posedge Clk);
      #1;
    end
    inValid[1] = 1'b0;
    checkOutput("ripple_valid", outValid[1], 1);
    checkOutput("ripple_sum", outSum[1], 16'h0000);
    checkOutput("ripple_cout", outCout[1], 1);
    checkOutput("done_cla_a", claA[1], 0);
    checkOutput("done_cla_b", claB[1], 0);
    checkOutput("done_cla_cin", claCin[1], 0);
    @(posedge Clk); #1;

    // SETTLE=0 instance: four cycles per operation
    curK = 0;
    applyStimulus(0, 16'hFFFF, 16'h0000, 1'b1);
    waitValid(0, n);
    checkOutput("s0_latency", n, 4);
    checkOutput("s0_sum", outSum[0], 16'h0000);
    checkOutput("s0_cout", outCout[0], 1);
    @(posedge Clk); #1;
    curK = 1;

    // Back-pressure in DONE with in_valid asserted throughout
    outReady[1] = 1'b0;
    applyStimulus(1, 16'h1234, 16'h4321, 1'b0);
    waitValid(1, n);
    checkOutput("hold_latency", n, 8);
    inValid[1] = 1'b1;
    inA[1] = 16'hAAAA;
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_valid", outValid[1], 1);
      checkOutput("hold_sum", outSum[1], 16'h5555);
      checkOutput("hold_in_ready", inReady[1], 0);
      @(posedge Clk); #1;
    end
    outReady[1] = 1'b1;
    @(posedge Clk); #1;
    checkOutput("release_valid", outValid[1], 0);
    checkOutput("release_in_ready", inReady[1], 1);
    checkOutput("release_no_accept", busy[1], 0);
    inValid[1] = 1'b0;
    @(posedge Clk); #1;

    // Reset pulse during nibble 2 discards the operation
    applyStimulus(1, 16'h00FF, 16'h0001, 1'b0);
    repeat (4) @(posedge Clk);
    #1;
    Rs = 1'b0;
    #1;
    checkResetState(1);
    sbQ.delete();
    @(negedge Clk);
    Rs = 1'b1;
    @(posedge Clk); #1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (outValid[1]) seen = 1'b1;
      @(posedge Clk); #1;
    end
    checkOutput("no_valid_after_reset", seen, 0);
    applyStimulus(1, 16'h0001, 16'h0001, 1'b0);
    waitValid(1, n);
    checkOutput("post_reset_latency", n, 8);
    checkOutput("post_reset_sum", outSum[1], 16'h0002);
    checkOutput("post_reset_cout", outCout[1], 0);
    @(posedge Clk); #1;

    // Random traffic per instance with input gaps and random out_ready
    for (int k = 0; k < 3; k++) begin
      curK = k;
      prevValid = 1'b0;
      for (int i = 0; i < ((k == 0) ? 334 : 333); i++) begin
        int t;
        bit done;
        repeat ($urandom_range(0, 3)) begin
          @(posedge Clk); #1;
        end
        applyStimulus(k, 16'($urandom), 16'($urandom), 1'($urandom));
        t = 0;
        done = 1'b0;
        while (!done && t < 300) begin
          outReady[k] = 1'($urandom);
          if (outValid[k] && outReady[k]) begin
            inValid[k] = 1'b0;
            done = 1'b1;
          end else begin
            inValid[k] = 1'($urandom);
            inA[k] = 16'($urandom);
          end
          @(posedge Clk); #1;
          t++;
        end
        inValid[k] = 1'b0;
        if (!done) checkOutput("rand_timeout", t, 0);
      end
      outReady[k] = 1'b1;
    end

    checkOutput("sb_drained", sbQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
